// File: rtl/executor_movimentos.sv
// Move executor for the cube solver: validates one command (flip, rotate the
// whole cube, or rotate the bottom layer), sequences the lid, flipper and base
// servo requests, tracks base position and lid state, and guards every servo
// handshake with a watchdog.
module executor_movimentos #(
  parameter int TIMEOUT = 100_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [1:0] tipo,
  input  logic [1:0] quantidade,
  input  logic       sentido,
  input  logic       pronto_servos,
  output logic       move_servo_peteleco,
  output logic       move_servo_tampa,
  output logic       move_servo_base,
  output logic [1:0] posicao_base,
  output logic       tampa_fechada,
  output logic       ocupado,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado
);

  // Watchdog only has to hold TIMEOUT-1; keep at least two bits for tiny TIMEOUTs.
  localparam int WD_W = (TIMEOUT > 4) ? $clog2(TIMEOUT) : 2;
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT - 1);

  localparam logic [1:0] TIPO_PETELECO = 2'b00;
  localparam logic [1:0] TIPO_CUBO     = 2'b01;
  localparam logic [1:0] TIPO_CAMADA   = 2'b10;
  localparam logic [1:0] TIPO_INVALIDO = 2'b11;

  typedef enum logic [3:0] {
    INICIAL         = 4'd0,
    VALIDA          = 4'd1,
    PEDE_TAMPA      = 4'd2,
    ESPERA_TAMPA    = 4'd3,
    PEDE_PASSO      = 4'd4,
    ESPERA_PASSO    = 4'd5,
    PEDE_RESTAURA   = 4'd6,
    ESPERA_RESTAURA = 4'd7,
    FIM             = 4'd8,
    ERRO            = 4'd9
  } estado_t;

  estado_t         r_estado;
  logic [1:0]      r_tipo;
  logic [1:0]      r_quant;
  logic            r_sentido;
  logic [1:0]      r_restantes;
  logic [1:0]      r_pos;
  logic            r_tampa;
  logic [WD_W-1:0] r_wd;

  logic            w_base;
  logic [1:0]      w_alvo;
  logic            w_em_passo;
  logic            w_fora_faixa;
  logic            w_invalido;
  logic            w_tampa_req;
  logic [WD_W-1:0] w_wd_inc;
  logic            w_wd_estouro;

  // Base moves change the position; the flipper never does.
  assign w_base     = (r_tipo == TIPO_CUBO) || (r_tipo == TIPO_CAMADA);
  assign w_alvo     = r_sentido ? (r_pos + 2'd1) : (r_pos - 2'd1);
  assign w_em_passo = (r_estado == PEDE_PASSO) || (r_estado == ESPERA_PASSO);

  // The whole sequence of steps must stay within 0..180 degrees.
  assign w_fora_faixa = r_sentido ? (({1'b0, r_pos} + {1'b0, r_quant}) > 3'd2)
                                  : (r_quant > r_pos);
  assign w_invalido   = (r_tipo == TIPO_INVALIDO) || (r_quant == 2'd0) ||
                        (w_base && w_fora_faixa);

  // Layer rotation needs the lid closed; flips and whole-cube turns need it open.
  assign w_tampa_req = (r_tipo == TIPO_CAMADA);

  // Trip one cycle early so erro shows exactly TIMEOUT cycles after the request.
  assign w_wd_inc     = r_wd + {{(WD_W-1){1'b0}}, 1'b1};
  assign w_wd_estouro = (w_wd_inc >= WD_LIM);

  // Control FSM: command latch, servo sequencing, position/lid tracking, watchdog.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado    <= INICIAL;
      r_tipo      <= 2'b00;
      r_quant     <= 2'd0;
      r_sentido   <= 1'b0;
      r_restantes <= 2'd0;
      r_pos       <= 2'd0;
      r_tampa     <= 1'b0;
      r_wd        <= '0;
    end else begin
      case (r_estado)
        INICIAL: begin
          if (iniciar) begin
            r_tipo      <= tipo;
            r_quant     <= quantidade;
            r_sentido   <= sentido;
            r_restantes <= quantidade;
            r_estado    <= VALIDA;
          end
        end

        VALIDA: begin
          if (w_invalido)
            r_estado <= ERRO;
          else if (r_tampa != w_tampa_req)
            r_estado <= PEDE_TAMPA;
          else
            r_estado <= PEDE_PASSO;
        end

        PEDE_TAMPA: begin
          r_wd     <= '0;
          r_estado <= ESPERA_TAMPA;
        end

        ESPERA_TAMPA: begin
          if (pronto_servos) begin
            r_tampa  <= ~r_tampa;
            r_estado <= PEDE_PASSO;
          end else if (w_wd_estouro) begin
            r_estado <= ERRO;
          end else begin
            r_wd <= w_wd_inc;
          end
        end

        PEDE_PASSO: begin
          r_wd     <= '0;
          r_estado <= ESPERA_PASSO;
        end

        ESPERA_PASSO: begin
          if (pronto_servos) begin
            r_restantes <= r_restantes - 2'd1;
            if (w_base)
              r_pos <= w_alvo;
            if (r_restantes == 2'd1)
              r_estado <= (r_tipo == TIPO_CAMADA) ? PEDE_RESTAURA : FIM;
            else
              r_estado <= PEDE_PASSO;
          end else if (w_wd_estouro) begin
            r_estado <= ERRO;
          end else begin
            r_wd <= w_wd_inc;
          end
        end

        PEDE_RESTAURA: begin
          r_wd     <= '0;
          r_estado <= ESPERA_RESTAURA;
        end

        ESPERA_RESTAURA: begin
          if (pronto_servos) begin
            r_tampa  <= ~r_tampa;
            r_estado <= FIM;
          end else if (w_wd_estouro) begin
            r_estado <= ERRO;
          end else begin
            r_wd <= w_wd_inc;
          end
        end

        FIM: begin
          r_estado <= INICIAL;
        end

        ERRO: begin
          if (iniciar)
            r_estado <= INICIAL;
        end

        default: begin
          r_estado <= INICIAL;
        end
      endcase
    end
  end

  // Outputs decode the state register only, so they are glitch-free and one-hot
  // across the request lines by construction.
  assign move_servo_tampa    = (r_estado == PEDE_TAMPA) || (r_estado == PEDE_RESTAURA);
  assign move_servo_peteleco = (r_estado == PEDE_PASSO) && (r_tipo == TIPO_PETELECO);
  assign move_servo_base     = (r_estado == PEDE_PASSO) && w_base;
  assign posicao_base        = (w_em_passo && w_base) ? w_alvo : r_pos;
  assign tampa_fechada       = r_tampa;
  assign ocupado             = (r_estado >= VALIDA) && (r_estado <= ESPERA_RESTAURA);
  assign pronto              = (r_estado == FIM);
  assign erro                = (r_estado == ERRO);
  assign db_estado           = r_estado;

endmodule

// File: tb/tb_executor_movimentos.sv
// Directed bench for executor_movimentos: flip, layer rotation, range error,
// watchdog timeout, reset mid-handshake and invalid commands.
module tb_executor_movimentos;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic [1:0] tipo = 2'b00;
  logic [1:0] quantidade = 2'd0;
  logic       sentido = 1'b0;
  logic       pronto_servos = 1'b0;
  logic       move_servo_peteleco;
  logic       move_servo_tampa;
  logic       move_servo_base;
  logic [1:0] posicao_base;
  logic       tampa_fechada;
  logic       ocupado;
  logic       pronto;
  logic       erro;
  logic [3:0] db_estado;

  int n_vec = 0;
  int n_err = 0;

  int cnt_pet = 0;
  int cnt_tam = 0;
  int cnt_base = 0;
  int cnt_pronto = 0;
  int cnt_multi = 0;

  executor_movimentos #(.TIMEOUT(20)) dut (
    .clock              (clock),
    .reset              (reset),
    .iniciar            (iniciar),
    .tipo               (tipo),
    .quantidade         (quantidade),
    .sentido            (sentido),
    .pronto_servos      (pronto_servos),
    .move_servo_peteleco(move_servo_peteleco),
    .move_servo_tampa   (move_servo_tampa),
    .move_servo_base    (move_servo_base),
    .posicao_base       (posicao_base),
    .tampa_fechada      (tampa_fechada),
    .ocupado            (ocupado),
    .pronto             (pronto),
    .erro               (erro),
    .db_estado          (db_estado)
  );

  always #5 clock = ~clock;

  // Pulse tally sampled mid-cycle.
  always @(negedge clock) begin
    if (move_servo_peteleco) cnt_pet++;
    if (move_servo_tampa)    cnt_tam++;
    if (move_servo_base)     cnt_base++;
    if (pronto)              cnt_pronto++;
    if ((32'(move_servo_peteleco) + 32'(move_servo_tampa) + 32'(move_servo_base)) > 1)
      cnt_multi++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic start(input logic [1:0] t, input logic [1:0] q, input logic s);
    tipo = t;
    quantidade = q;
    sentido = s;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask

  task automatic pulse_pronto();
    pronto_servos = 1'b1;
    tick();
    pronto_servos = 1'b0;
  endtask

  // Wait (bounded) for any servo request, then answer it two cycles later.
  task automatic serve();
    int k;
    k = 0;
    while (!(move_servo_peteleco || move_servo_tampa || move_servo_base) && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) begin
      chk("serve_timeout", 32'd0, 32'd1);
    end else begin
      tick();
      tick();
      pulse_pronto();
    end
  endtask

  int s_pet, s_tam, s_base, s_pronto, k_err;

  initial begin
    // Reset state
    do_reset();
    chk("rst_estado", 32'(db_estado), 32'd0);
    chk("rst_tampa", 32'(tampa_fechada), 32'd0);
    chk("rst_posicao", 32'(posicao_base), 32'd0);
    chk("rst_flags", {29'd0, ocupado, pronto, erro}, 32'd0);

    // Two flips
    s_pet = cnt_pet; s_tam = cnt_tam; s_pronto = cnt_pronto;
    start(2'b00, 2'd2, 1'b0);
    chk("flip_valida", 32'(db_estado), 32'd1);
    chk("flip_ocupado", 32'(ocupado), 32'd1);
    tick();
    chk("flip_pede1", 32'(db_estado), 32'd4);
    chk("flip_pet1", 32'(move_servo_peteleco), 32'd1);
    tick();
    tick();
    pulse_pronto();
    chk("flip_pede2", 32'(db_estado), 32'd4);
    tick();
    chk("flip_espera2", 32'(db_estado), 32'd5);
    pulse_pronto();
    chk("flip_fim", 32'(pronto), 32'd1);
    tick();
    chk("flip_inicial", 32'(db_estado), 32'd0);
    chk("flip_n_pet", 32'(cnt_pet - s_pet), 32'd2);
    chk("flip_n_tam", 32'(cnt_tam - s_tam), 32'd0);
    chk("flip_n_pronto", 32'(cnt_pronto - s_pronto), 32'd1);
    chk("flip_tampa", 32'(tampa_fechada), 32'd0);

    // Bottom layer +90 from reset
    do_reset();
    s_tam = cnt_tam; s_base = cnt_base;
    start(2'b10, 2'd1, 1'b1);
    tick();
    chk("cam_pede_tampa", 32'(db_estado), 32'd2);
    chk("cam_tam1", 32'(move_servo_tampa), 32'd1);
    tick();
    tick();
    pulse_pronto();
    chk("cam_fechada", 32'(tampa_fechada), 32'd1);
    chk("cam_base", 32'(move_servo_base), 32'd1);
    chk("cam_alvo", 32'(posicao_base), 32'd1);
    tick();
    chk("cam_alvo_espera", 32'(posicao_base), 32'd1);
    pulse_pronto();
    chk("cam_restaura", 32'(move_servo_tampa), 32'd1);
    chk("cam_restaura_st", 32'(db_estado), 32'd6);
    tick();
    pulse_pronto();
    chk("cam_pronto", 32'(pronto), 32'd1);
    tick();
    chk("cam_pos", 32'(posicao_base), 32'd1);
    chk("cam_tampa", 32'(tampa_fechada), 32'd0);
    chk("cam_n_tam", 32'(cnt_tam - s_tam), 32'd2);
    chk("cam_n_base", 32'(cnt_base - s_base), 32'd1);

    // Whole cube +90 to reach 180 deg, then another +90 is out of range
    start(2'b01, 2'd1, 1'b1);
    serve();
    tick();
    chk("cubo_pos2", 32'(posicao_base), 32'd2);
    chk("cubo_tampa", 32'(tampa_fechada), 32'd0);
    s_pet = cnt_pet; s_tam = cnt_tam; s_base = cnt_base;
    start(2'b01, 2'd1, 1'b1);
    tick();
    chk("faixa_erro_st", 32'(db_estado), 32'd9);
    chk("faixa_erro", 32'(erro), 32'd1);
    chk("faixa_ocupado", 32'(ocupado), 32'd0);
    tick();
    chk("faixa_sticky", 32'(erro), 32'd1);
    chk("faixa_sem_req", 32'((cnt_pet - s_pet) + (cnt_tam - s_tam) + (cnt_base - s_base)), 32'd0);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("faixa_volta", 32'(db_estado), 32'd0);
    tick();
    chk("faixa_nao_trava", 32'(db_estado), 32'd0);
    chk("faixa_pos", 32'(posicao_base), 32'd2);

    // Watchdog: whole cube -90 from 180 deg with no completion
    start(2'b01, 2'd1, 1'b0);
    tick();
    chk("wd_base", 32'(move_servo_base), 32'd1);
    chk("wd_alvo", 32'(posicao_base), 32'd1);
    k_err = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (erro && k_err == 0) k_err = i;
    end
    chk("wd_ciclos", 32'(k_err), 32'd20);
    chk("wd_pos", 32'(posicao_base), 32'd2);
    chk("wd_estado", 32'(db_estado), 32'd9);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;

    // Reset in the middle of a layer step
    do_reset();
    start(2'b10, 2'd1, 1'b0 ^ 1'b1);
    tick();
    tick();
    pulse_pronto();
    tick();
    chk("mid_espera", 32'(db_estado), 32'd5);
    chk("mid_fechada", 32'(tampa_fechada), 32'd1);
    do_reset();
    chk("mid_rst_estado", 32'(db_estado), 32'd0);
    chk("mid_rst_tampa", 32'(tampa_fechada), 32'd0);
    chk("mid_rst_pos", 32'(posicao_base), 32'd0);
    s_pet = cnt_pet; s_tam = cnt_tam; s_base = cnt_base; s_pronto = cnt_pronto;
    pulse_pronto();
    tick();
    chk("mid_ign_estado", 32'(db_estado), 32'd0);
    chk("mid_ign_flags", {29'd0, ocupado, pronto, erro}, 32'd0);
    chk("mid_ign_req", 32'((cnt_pet - s_pet) + (cnt_tam - s_tam) + (cnt_base - s_base) + (cnt_pronto - s_pronto)), 32'd0);

    // Invalid commands
    s_pet = cnt_pet; s_tam = cnt_tam; s_base = cnt_base;
    start(2'b00, 2'd0, 1'b0);
    tick();
    chk("q0_erro", 32'(db_estado), 32'd9);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    start(2'b11, 2'd1, 1'b0);
    tick();
    chk("t11_erro", 32'(db_estado), 32'd9);
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    chk("inv_sem_req", 32'((cnt_pet - s_pet) + (cnt_tam - s_tam) + (cnt_base - s_base)), 32'd0);
    chk("inv_volta", 32'(db_estado), 32'd0);

    chk("one_hot_req", 32'(cnt_multi), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
